// File: rtl/vec_pack.sv
// Rounds/shifts/saturates a stream of accumulator scalars into DIMENSION-lane packed vectors.
// out_valid rises 1 cycle after completion; completion stalls in_ready until the output register frees.
module vec_pack #(
    parameter int DIMENSION = 16,
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20,
    parameter int SHIFT     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ACC_WIDTH-1:0]             in_data,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DIMENSION*WIDTH-1:0]       out_vec,
    output logic [$clog2(DIMENSION+1)-1:0]   out_len,
    output logic                             out_sat
);

    localparam int IW = $clog2(DIMENSION);
    localparam int LW = $clog2(DIMENSION+1);
    localparam int AW = ACC_WIDTH + 1;
    localparam logic signed [AW-1:0] RND = AW'((2**SHIFT) / 2);
    localparam logic signed [AW-1:0] HI  = AW'(2**(WIDTH-1) - 1);
    localparam logic signed [AW-1:0] LO  = ~HI;

    typedef struct packed {
        logic [DIMENSION*WIDTH-1:0] vec;
        logic [LW-1:0]              len;
        logic                       sat;
    } outreg_t;

    logic [IW-1:0]                   idx;
    logic                            flush_pend;
    logic [DIMENSION-1:0][WIDTH-1:0] lane_q, lane_nxt;
    logic [DIMENSION-1:0]            sat_q, sat_nxt;
    outreg_t                         outr;

    logic signed [AW-1:0] sum, shr;
    logic [WIDTH-1:0]     lane_val;
    logic                 lane_sat;
    logic                 xfer_ok, last, acc, flush_evt, complete;
    logic [LW-1:0]        fill;

    assign xfer_ok   = !out_valid || out_ready;
    assign last      = (idx == IW'(DIMENSION-1));
    assign in_ready  = rst && ((!last && !flush_pend) || xfer_ok);
    assign acc       = in_valid && in_ready;
    assign fill      = LW'(idx) + LW'(acc);
    assign flush_evt = flush || flush_pend;
    assign complete  = xfer_ok && ((acc && last) || (flush_evt && fill != '0));

    // Extra sign bit keeps the rounding add from overflowing.
    always_comb begin
        sum      = $signed({in_data[ACC_WIDTH-1], in_data}) + RND;
        shr      = sum >>> SHIFT;
        lane_val = shr[WIDTH-1:0];
        lane_sat = 1'b0;
        if (shr > HI) begin
            lane_val = HI[WIDTH-1:0];
            lane_sat = 1'b1;
        end else if (shr < LO) begin
            lane_val = LO[WIDTH-1:0];
            lane_sat = 1'b1;
        end
    end

    always_comb begin
        lane_nxt = lane_q;
        sat_nxt  = sat_q;
        if (acc) begin
            lane_nxt[idx] = lane_val;
            sat_nxt[idx]  = lane_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx        <= '0;
            flush_pend <= 1'b0;
            lane_q     <= '0;
            sat_q      <= '0;
            outr       <= '0;
            out_valid  <= 1'b0;
        end else if (complete) begin
            // Unfilled lanes are already zero since the buffer clears on every completion.
            idx        <= '0;
            flush_pend <= 1'b0;
            lane_q     <= '0;
            sat_q      <= '0;
            outr       <= '{vec: lane_nxt, len: fill, sat: |sat_nxt};
            out_valid  <= 1'b1;
        end else begin
            if (acc) begin
                idx    <= idx + IW'(1);
                lane_q <= lane_nxt;
                sat_q  <= sat_nxt;
            end
            if (flush && fill != '0)
                flush_pend <= 1'b1;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
        end
    end

    assign out_vec = outr.vec;
    assign out_len = outr.len;
    assign out_sat = outr.sat;

endmodule

// File: tb/tb_vec_pack.sv
// Directed bench for vec_pack with DIMENSION=4, WIDTH=8, ACC_WIDTH=16, SHIFT=4.
module tb_vec_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_vec;
    logic [2:0]  out_len;
    logic        out_sat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vec_pack #(.DIMENSION(4), .WIDTH(8), .ACC_WIDTH(16), .SHIFT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_len(out_len), .out_sat(out_sat)
    );

    typedef struct {
        logic [3:0][15:0] d;
        logic [31:0]      vec;
        logic             sat;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic f, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = ordy;
    endtask

    // Feeds four scalars with out_ready=1 and checks the vector one cycle after the last accept.
    task automatic feed4(input string nm, input logic [3:0][15:0] d,
                         input logic [31:0] vec, input logic sat);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, d[i], 1'b0, 1'b1);
            @(negedge clk);
            chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
            if (i == 3) chk({nm, "_early_valid"}, 32'(out_valid), 32'd0);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_vec"}, out_vec, vec);
        chk({nm, "_len"}, 32'(out_len), 32'd4);
        chk({nm, "_sat"}, 32'(out_sat), 32'(sat));
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk({nm, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        int vcyc[$];
        logic [31:0] vval[$];
        int lowcnt;

        tbl[0].d = {16'h0008, 16'hFFE8, 16'h0018, 16'h0123}; tbl[0].vec = 32'h01FF0212; tbl[0].sat = 1'b0;
        tbl[1].d = {16'h0000, 16'hFFF8, 16'h8000, 16'h7FFF}; tbl[1].vec = 32'h0000807F; tbl[1].sat = 1'b1;
        tbl[2].d = {16'h07F8, 16'h07F7, 16'hFFF7, 16'h0008}; tbl[2].vec = 32'h7F7FFF01; tbl[2].sat = 1'b1;
        tbl[3].d = {16'h0007, 16'hF7F7, 16'hF7F8, 16'hF808}; tbl[3].vec = 32'h00808081; tbl[3].sat = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_vec", out_vec, 32'd0);
        chk("rst_len", 32'(out_len), 32'd0);
        chk("rst_sat", 32'(out_sat), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        for (int t = 0; t < 4; t++)
            feed4($sformatf("tbl%0d", t), tbl[t].d, tbl[t].vec, tbl[t].sat);

        // Flush joined with the second accept
        drive(1'b1, 16'd24, 1'b0, 1'b1);
        drive(1'b1, 16'd8, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("flush_valid", 32'(out_valid), 32'd1);
        chk("flush_vec", out_vec, 32'h00000102);
        chk("flush_len", 32'(out_len), 32'd2);
        chk("flush_sat", 32'(out_sat), 32'd0);
        // Flush with nothing to emit
        drive(1'b0, '0, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("empty_flush_a", 32'(out_valid), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("empty_flush_b", 32'(out_valid), 32'd0);

        // Backpressure: first vector held, three more accepted, then stall
        for (int k = 1; k <= 7; k++) begin
            drive(1'b1, 16'(k * 16), 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("bp_rdy%0d", k), 32'(in_ready), 32'd1);
        end
        drive(1'b1, 16'd128, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_stall", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_vec", out_vec, 32'h04030201);
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_rdy", 32'(in_ready), 32'd1);
        chk("bp_first_vec", out_vec, 32'h04030201);
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        chk("bp_second_vec", out_vec, 32'h08070605);
        chk("bp_second_len", 32'(out_len), 32'd4);
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("bp_drain", 32'(out_valid), 32'd0);

        // Flush latched while the output register is occupied
        for (int k = 1; k <= 4; k++) drive(1'b1, 16'(k * 16), 1'b0, 1'b0);
        drive(1'b1, 16'd80, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b1, 16'd96, 1'b0, 1'b0);
        @(negedge clk);
        chk("fp_block", 32'(in_ready), 32'd0);
        chk("fp_hold_vec", out_vec, 32'h04030201);
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("fp_valid", 32'(out_valid), 32'd1);
        chk("fp_vec", out_vec, 32'h00000005);
        chk("fp_len", 32'(out_len), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("fp_drain", 32'(out_valid), 32'd0);

        // Streaming: 12 scalars, one vector every 4 cycles
        lowcnt = 0;
        for (int c = 0; c < 15; c++) begin
            if (c < 12) drive(1'b1, 16'((c + 1) * 16), 1'b0, 1'b1);
            else        drive(1'b0, '0, 1'b0, 1'b1);
            @(negedge clk);
            if (c < 12 && !in_ready) lowcnt++;
            if (out_valid) begin
                vcyc.push_back(c);
                vval.push_back(out_vec);
            end
        end
        vcnt = vcyc.size();
        chk("st_ready_low", 32'(lowcnt), 32'd0);
        chk("st_count", 32'(vcnt), 32'd3);
        if (vcnt == 3) begin
            chk("st_cyc0", 32'(vcyc[0]), 32'd4);
            chk("st_cyc1", 32'(vcyc[1]), 32'd8);
            chk("st_cyc2", 32'(vcyc[2]), 32'd12);
            chk("st_vec0", vval[0], 32'h04030201);
            chk("st_vec1", vval[1], 32'h08070605);
            chk("st_vec2", vval[2], 32'h0C0B0A09);
        end

        // Reset mid-vector
        drive(1'b1, 16'h0090, 1'b0, 1'b1);
        drive(1'b1, 16'h00A0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_in_ready", 32'(in_ready), 32'd0);
        chk("mr_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        feed4("mr", {16'd64, 16'd48, 16'd32, 16'd16}, 32'h04030201, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
